// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder: FSM states and sck edge kinds.
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } sck_edge_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Optional synchronizer stages on sck/cs/mosi, followed by sck edge detection
// against the previous-cycle sck value.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic sck_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic cs_o,
    output logic mosi_o,
    output logic rise_o,
    output logic fall_o
);

    logic sck_s;
    logic sck_q;

    if (SYNC_STAGES == 0) begin : g_direct
        assign sck_s  = sck_i;
        assign cs_o   = cs_i;
        assign mosi_o = mosi_i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sck_pipe_q;
        logic [SYNC_STAGES-1:0] cs_pipe_q;
        logic [SYNC_STAGES-1:0] mosi_pipe_q;

        // cs stages reset high so a reset never looks like a select.
        always_ff @(posedge clk) begin
            if (!reset) begin
                sck_pipe_q  <= '0;
                cs_pipe_q   <= '1;
                mosi_pipe_q <= '0;
            end else begin
                sck_pipe_q  <= SYNC_STAGES'({sck_pipe_q, sck_i});
                cs_pipe_q   <= SYNC_STAGES'({cs_pipe_q, cs_i});
                mosi_pipe_q <= SYNC_STAGES'({mosi_pipe_q, mosi_i});
            end
        end

        assign sck_s  = sck_pipe_q[SYNC_STAGES-1];
        assign cs_o   = cs_pipe_q[SYNC_STAGES-1];
        assign mosi_o = mosi_pipe_q[SYNC_STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= sck_s;
        end
    end

    assign rise_o = sck_s & ~sck_q;
    assign fall_o = ~sck_s & sck_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder on the master's clk: shifts words in on sck rise, returns the
// preloaded holding word MSB first on miso, shifting on sck fall.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_empty,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              overrun,
    input  logic              rx_ack,
    output logic              frame_err
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic      cs_s;
    logic      mosi_s;
    logic      rise;
    logic      fall;
    sck_edge_e sck_edge;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0] tx_sr_q,     tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q,     rx_sr_d;
    logic [DATA_W-1:0] hold_q,      hold_d;
    logic [DATA_W-1:0] rx_data_q,   rx_data_d;
    logic              tx_empty_q,  tx_empty_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              overrun_q,   overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              pending_q,   pending_d;
    logic              reload;

    spi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .sck_i  (sck),
        .cs_i   (cs),
        .mosi_i (mosi),
        .cs_o   (cs_s),
        .mosi_o (mosi_s),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        sck_edge = EDGE_NONE;
        if (rise) begin
            sck_edge = EDGE_RISE;
        end else if (fall) begin
            sck_edge = EDGE_FALL;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        hold_d      = hold_q;
        tx_empty_d  = tx_empty_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        pending_d   = rx_ack ? 1'b0 : pending_q;
        reload      = 1'b0;
        miso        = 1'b0;
        miso_oe     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    reload    = 1'b1;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                miso    = tx_sr_q[DATA_W-1];
                miso_oe = 1'b1;
                if (cs_s) begin
                    // bit_cnt wraps to 0 on the last bit, so nonzero means a partial word.
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                end else begin
                    case (sck_edge)
                        EDGE_RISE: begin
                            rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_s};
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_d  = '0;
                                rx_data_d  = {rx_sr_q[DATA_W-2:0], mosi_s};
                                rx_valid_d = 1'b1;
                                overrun_d  = pending_q & ~rx_ack;
                                pending_d  = 1'b1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            end
                        end
                        EDGE_FALL: begin
                            if (bit_cnt_q == '0) begin
                                reload = 1'b1;
                            end else begin
                                tx_sr_d = tx_sr_q << 1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        // A reload consumes the old hold; a same-cycle tx_load then refills it.
        if (reload) begin
            tx_sr_d    = tx_empty_q ? '0 : hold_q;
            tx_empty_d = 1'b1;
        end
        if (tx_load) begin
            hold_d     = tx_data;
            tx_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            hold_q      <= '0;
            tx_empty_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            hold_q      <= hold_d;
            tx_empty_q  <= tx_empty_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            pending_q   <= pending_d;
        end
    end

    assign tx_empty  = tx_empty_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: the bench plays SPI master, checks a vector table,
// hand-written corner sequences and random frames against a word-level model.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       rx_ack;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    int         rv_cnt = 0;
    int         ov_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] rx_log[$];

    spi_slave #(
        .DATA_W      (8),
        .SYNC_STAGES (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_empty  (tx_empty),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .overrun   (overrun),
        .rx_ack    (rx_ack),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles, so a stuck pulse shows up as extra counts.
    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt++;
            rx_log.push_back(rx_data);
        end
        if (overrun)   ov_cnt++;
        if (frame_err) fe_cnt++;
    end

    typedef struct {
        logic       load;
        logic [7:0] tx;
        logic [7:0] mo;
        logic       ack;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_hold(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic ack_word();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(2);
    endtask

    task automatic cs_high();
        tick(2);
        cs = 1'b1;
        tick(3);
    endtask

    // Master side: present a bit, raise sck, sample miso, lower sck.
    task automatic send_bits(input logic [7:0] w, input int nbits, input logic mid_load,
                             input logic [7:0] mid_data, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            if (mid_load && i == 3) begin
                tx_data = mid_data;
                tx_load = 1'b1;
                tick(1);
                tx_load = 1'b0;
                tick(1);
            end else begin
                tick(2);
            end
            sck = 1'b1;
            tick(2);
            got  = {got[6:0], miso};
            sck  = 1'b0;
        end
    endtask

    function automatic logic [7:0] last_rx(input int back);
        if (rx_log.size() > back) return rx_log[rx_log.size() - 1 - back];
        return 8'hxx;
    endfunction

    vec_t       vecs[5];
    logic [7:0] got;
    logic [7:0] got2;
    int         rv0, ov0, fe0;
    logic       m_pending;
    logic       r_load, r_ack;
    logic [7:0] r_tx, r_mo, r_exp_miso;
    int         r_exp_ov;

    initial begin
        vecs[0] = '{load: 1'b1, tx: 8'hA5, mo: 8'h3C, ack: 1'b1, exp_miso: 8'hA5, exp_rx: 8'h3C, exp_ov: 0};
        vecs[1] = '{load: 1'b0, tx: 8'h00, mo: 8'h96, ack: 1'b1, exp_miso: 8'h00, exp_rx: 8'h96, exp_ov: 0};
        vecs[2] = '{load: 1'b1, tx: 8'h77, mo: 8'h11, ack: 1'b0, exp_miso: 8'h77, exp_rx: 8'h11, exp_ov: 0};
        vecs[3] = '{load: 1'b0, tx: 8'h00, mo: 8'h22, ack: 1'b1, exp_miso: 8'h00, exp_rx: 8'h22, exp_ov: 1};
        vecs[4] = '{load: 1'b1, tx: 8'hFF, mo: 8'h00, ack: 1'b1, exp_miso: 8'hFF, exp_rx: 8'h00, exp_ov: 0};

        reset   = 1'b0;
        sck     = 1'b0;
        cs      = 1'b1;
        mosi    = 1'b0;
        tx_data = '0;
        tx_load = 1'b0;
        rx_ack  = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);

        check("rst_miso",     miso,      0);
        check("rst_miso_oe",  miso_oe,   0);
        check("rst_tx_empty", tx_empty,  1);
        check("rst_rx_data",  rx_data,   0);
        check("rst_rx_valid", rx_valid,  0);
        check("rst_overrun",  overrun,   0);
        check("rst_frame_err", frame_err, 0);

        // Vector table: one frame per entry.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].load) load_hold(vecs[i].tx);
            check($sformatf("vec%0d_tx_empty_pre", i), tx_empty, !vecs[i].load);
            rv0 = rv_cnt; ov0 = ov_cnt; fe0 = fe_cnt;
            cs_low();
            check($sformatf("vec%0d_miso_oe", i), miso_oe, 1);
            check($sformatf("vec%0d_tx_empty_mid", i), tx_empty, 1);
            send_bits(vecs[i].mo, 8, 1'b0, 8'h00, got);
            cs_high();
            check($sformatf("vec%0d_miso_word", i), got, vecs[i].exp_miso);
            check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_rx);
            check($sformatf("vec%0d_rx_valid_cnt", i), rv_cnt - rv0, 1);
            check($sformatf("vec%0d_overrun_cnt", i), ov_cnt - ov0, vecs[i].exp_ov);
            check($sformatf("vec%0d_frame_err_cnt", i), fe_cnt - fe0, 0);
            check($sformatf("vec%0d_tx_empty_post", i), tx_empty, 1);
            if (vecs[i].ack) ack_word();
        end

        // Aborted frame after 3 bits, then a clean frame.
        rv0 = rv_cnt; fe0 = fe_cnt;
        cs_low();
        send_bits(8'hE7, 3, 1'b0, 8'h00, got);
        cs_high();
        check("abort_frame_err_cnt", fe_cnt - fe0, 1);
        check("abort_rx_valid_cnt",  rv_cnt - rv0, 0);
        check("abort_idle_miso_oe",  miso_oe, 0);
        rv0 = rv_cnt; ov0 = ov_cnt; fe0 = fe_cnt;
        cs_low();
        send_bits(8'hF0, 8, 1'b0, 8'h00, got);
        cs_high();
        check("after_abort_rx_data", rx_data, 8'hF0);
        check("after_abort_rx_valid_cnt", rv_cnt - rv0, 1);
        check("after_abort_overrun_cnt", ov_cnt - ov0, 0);
        check("after_abort_frame_err_cnt", fe_cnt - fe0, 0);

        // Reset mid-frame with a word still pending and hold loaded.
        load_hold(8'h3E);
        cs_low();
        send_bits(8'hAA, 4, 1'b0, 8'h00, got);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("midrst_miso",      miso,      0);
        check("midrst_miso_oe",   miso_oe,   0);
        check("midrst_tx_empty",  tx_empty,  1);
        check("midrst_rx_data",   rx_data,   0);
        check("midrst_rx_valid",  rx_valid,  0);
        check("midrst_overrun",   overrun,   0);
        check("midrst_frame_err", frame_err, 0);
        cs = 1'b1;
        tick(3);
        rv0 = rv_cnt; ov0 = ov_cnt; fe0 = fe_cnt;
        cs_low();
        send_bits(8'h81, 8, 1'b0, 8'h00, got);
        cs_high();
        check("after_rst_rx_data", rx_data, 8'h81);
        check("after_rst_miso_word", got, 8'h00);
        check("after_rst_rx_valid_cnt", rv_cnt - rv0, 1);
        check("after_rst_overrun_cnt", ov_cnt - ov0, 0);
        check("after_rst_frame_err_cnt", fe_cnt - fe0, 0);
        ack_word();

        // Two words under one cs, hold refilled during the first word.
        load_hold(8'hC3);
        rv0 = rv_cnt; ov0 = ov_cnt; fe0 = fe_cnt;
        cs_low();
        send_bits(8'h12, 8, 1'b1, 8'h5A, got);
        send_bits(8'h34, 8, 1'b0, 8'h00, got2);
        cs_high();
        check("b2b_miso_word0", got,  8'hC3);
        check("b2b_miso_word1", got2, 8'h5A);
        check("b2b_rx_valid_cnt", rv_cnt - rv0, 2);
        check("b2b_rx_word0", last_rx(1), 8'h12);
        check("b2b_rx_word1", last_rx(0), 8'h34);
        check("b2b_overrun_cnt", ov_cnt - ov0, 1);
        check("b2b_frame_err_cnt", fe_cnt - fe0, 0);
        check("b2b_tx_empty", tx_empty, 1);
        ack_word();

        // Random frames against a word-level model of hold/pending behaviour.
        m_pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r_load = 1'($urandom_range(0, 1));
            r_ack  = 1'($urandom_range(0, 1));
            r_tx   = 8'($urandom);
            r_mo   = 8'($urandom);
            if (r_ack) begin
                ack_word();
                m_pending = 1'b0;
            end
            if (r_load) load_hold(r_tx);
            r_exp_miso = r_load ? r_tx : 8'h00;
            r_exp_ov   = m_pending ? 1 : 0;
            m_pending  = 1'b1;
            rv0 = rv_cnt; ov0 = ov_cnt; fe0 = fe_cnt;
            cs_low();
            send_bits(r_mo, 8, 1'b0, 8'h00, got);
            cs_high();
            check($sformatf("rnd%0d_rx_data", i), rx_data, r_mo);
            check($sformatf("rnd%0d_miso_word", i), got, r_exp_miso);
            check($sformatf("rnd%0d_rx_valid_cnt", i), rv_cnt - rv0, 1);
            check($sformatf("rnd%0d_overrun_cnt", i), ov_cnt - ov0, r_exp_ov);
            check($sformatf("rnd%0d_frame_err_cnt", i), fe_cnt - fe0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
